// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared ALU
//
// Purpose:
//   Two requesters share one external combinational ALU. In IDLE the arbiter
//   picks a requester, latches its function code and operands onto the ALU
//   inputs and pulses that requester's ack. One EXEC cycle later it captures
//   the ALU result and flags. It then holds them in RESP until the winning
//   requester accepts them.
//
// Parameters:
//   PRIO_FIXED  0 = round-robin on ties, 1 = requester 0 always wins ties
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0/1, fn0/1, a0/1, b0/1 request level, ALU function code, operands
//   ack0/1                    one-cycle grant pulse (operands captured)
//   rsp_valid0/1, rsp_ready0/1 response handshake, winner only
//   rsp_data, rsp_flags       captured ALU result and {Gz, Ez, Lz, Eq}
//   alu_in1, alu_in2, alu_fn  operands and function driven to the shared ALU
//   alu_out, alu_gz/ez/lz/eq  result and flags returned by the shared ALU
//   busy                      high whenever the FSM is not in IDLE

module alu_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0,
  input  logic [3:0]  fn0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  output logic        ack0,
  output logic        rsp_valid0,
  input  logic        rsp_ready0,

  input  logic        req1,
  input  logic [3:0]  fn1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        ack1,
  output logic        rsp_valid1,
  input  logic        rsp_ready1,

  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,

  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_fn,
  input  logic [31:0] alu_out,
  input  logic        alu_gz,
  input  logic        alu_ez,
  input  logic        alu_lz,
  input  logic        alu_eq,

  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;    // requester that owns the operation in flight
  logic        last_q,  last_d;     // requester granted most recently
  logic        ack0_q,  ack0_d;
  logic        ack1_q,  ack1_d;
  logic [31:0] data_q,  data_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] in1_q,   in1_d;
  logic [31:0] in2_q,   in2_d;
  logic [3:0]  fn_q,    fn_d;

  logic        any_req;
  logic        pick1;               // 1 when requester 1 wins this IDLE edge
  logic        owner_ready;

  assign any_req = req0 | req1;

  // A lone requester always wins. On a tie, fixed priority favours
  // requester 0. Round-robin favours whoever was not granted last.
  // Reset leaves last_q = 1, so requester 0 wins the first tie.
  always_comb begin
    pick1 = 1'b0;
    if (PRIO_FIXED != 0) begin
      pick1 = req1 & ~req0;
    end else begin
      pick1 = req1 & ~(req0 & last_q);
    end
  end

  // Only the owner's ready matters; the other requester's ready is ignored.
  assign owner_ready = owner_q ? rsp_ready1 : rsp_ready0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    data_d  = data_q;
    flags_d = flags_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    fn_d    = fn_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = pick1;
          last_d  = pick1;
          ack0_d  = ~pick1;
          ack1_d  = pick1;
          in1_d   = pick1 ? a1  : a0;
          in2_d   = pick1 ? b1  : b0;
          fn_d    = pick1 ? fn1 : fn0;
          state_d = ST_EXEC;
        end
      end

      // The ALU inputs have been stable for a full cycle.
      // Capture its output here.
      ST_EXEC: begin
        data_d  = alu_out;
        flags_d = {alu_gz, alu_ez, alu_lz, alu_eq};
        state_d = ST_RESP;
      end

      // Result and flags hold until the owner takes them.
      ST_RESP: begin
        if (owner_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      data_q  <= 32'd0;
      flags_q <= 4'd0;
      in1_q   <= 32'd0;
      in2_q   <= 32'd0;
      fn_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      fn_q    <= fn_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rsp_valid0 = (state_q == ST_RESP) & ~owner_q;
  assign rsp_valid1 = (state_q == ST_RESP) &  owner_q;
  assign rsp_data   = data_q;
  assign rsp_flags  = flags_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_fn     = fn_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter (round-robin and fixed priority)

module tb_alu_arbiter;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  fn0 = 4'h0, fn1 = 4'h0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        rsp_ready0 = 1'b0, rsp_ready1 = 1'b0;

  logic        rr_ack0, rr_ack1, rr_v0, rr_v1, rr_busy;
  logic [31:0] rr_data, rr_in1, rr_in2, rr_out;
  logic [3:0]  rr_flags, rr_fn;
  logic        rr_gz, rr_ez, rr_lz, rr_eq;

  logic        fx_ack0, fx_ack1, fx_v0, fx_v1, fx_busy;
  logic [31:0] fx_data, fx_in1, fx_in2, fx_out;
  logic [3:0]  fx_flags, fx_fn;
  logic        fx_gz, fx_ez, fx_lz, fx_eq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_res(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      default: return a & b;
    endcase
  endfunction

  // Behavioural stand-ins for the shared ALU in front of each instance.
  assign rr_out = alu_res(rr_fn, rr_in1, rr_in2);
  assign rr_gz  = ~rr_out[31] & (rr_out != 0);
  assign rr_ez  = (rr_out == 0);
  assign rr_lz  = rr_out[31];
  assign rr_eq  = (rr_in1 == rr_in2);

  assign fx_out = alu_res(fx_fn, fx_in1, fx_in2);
  assign fx_gz  = ~fx_out[31] & (fx_out != 0);
  assign fx_ez  = (fx_out == 0);
  assign fx_lz  = fx_out[31];
  assign fx_eq  = (fx_in1 == fx_in2);

  alu_arbiter #(.PRIO_FIXED(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .fn0(fn0), .a0(a0), .b0(b0), .ack0(rr_ack0),
    .rsp_valid0(rr_v0), .rsp_ready0(rsp_ready0),
    .req1(req1), .fn1(fn1), .a1(a1), .b1(b1), .ack1(rr_ack1),
    .rsp_valid1(rr_v1), .rsp_ready1(rsp_ready1),
    .rsp_data(rr_data), .rsp_flags(rr_flags),
    .alu_in1(rr_in1), .alu_in2(rr_in2), .alu_fn(rr_fn), .alu_out(rr_out),
    .alu_gz(rr_gz), .alu_ez(rr_ez), .alu_lz(rr_lz), .alu_eq(rr_eq),
    .busy(rr_busy)
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fx (
    .clk(clk), .rst(rst),
    .req0(req0), .fn0(fn0), .a0(a0), .b0(b0), .ack0(fx_ack0),
    .rsp_valid0(fx_v0), .rsp_ready0(rsp_ready0),
    .req1(req1), .fn1(fn1), .a1(a1), .b1(b1), .ack1(fx_ack1),
    .rsp_valid1(fx_v1), .rsp_ready1(rsp_ready1),
    .rsp_data(fx_data), .rsp_flags(fx_flags),
    .alu_in1(fx_in1), .alu_in2(fx_in2), .alu_fn(fx_fn), .alu_out(fx_out),
    .alu_gz(fx_gz), .alu_ez(fx_ez), .alu_lz(fx_lz), .alu_eq(fx_eq),
    .busy(fx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ack0", rr_ack0, 0);     chk("rst_ack1", rr_ack1, 0);
    chk("rst_v0", rr_v0, 0);         chk("rst_v1", rr_v1, 0);
    chk("rst_busy", rr_busy, 0);     chk("rst_data", rr_data, 0);
    chk("rst_flags", rr_flags, 0);   chk("rst_in1", rr_in1, 0);
    chk("rst_in2", rr_in2, 0);       chk("rst_fn", rr_fn, 0);

    // ---------------- single ADD 5+7 ----------------
    req0 = 1'b1; fn0 = FN_ADD; a0 = 32'd5; b0 = 32'd7; rsp_ready0 = 1'b1;
    step();                                   // grant edge
    req0 = 1'b0;
    chk("add_ack0", rr_ack0, 1);     chk("add_ack1", rr_ack1, 0);
    chk("add_busy", rr_busy, 1);     chk("add_v0_early", rr_v0, 0);
    chk("add_in1", rr_in1, 5);       chk("add_in2", rr_in2, 7);
    chk("add_fn", rr_fn, FN_ADD);
    step();                                   // EXEC edge
    chk("add_ack0_drop", rr_ack0, 0);
    chk("add_v0", rr_v0, 1);         chk("add_v1", rr_v1, 0);
    chk("add_data", rr_data, 12);    chk("add_flags", rr_flags, 4'b1000);
    step();                                   // ready taken in first RESP cycle
    chk("add_v0_one_cycle", rr_v0, 0);
    chk("add_idle", rr_busy, 0);
    chk("add_hold_in1", rr_in1, 5);

    // ---------------- ties from reset: RR alternates, fixed favours 0 ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; fn0 = FN_SUB; a0 = 32'd10; b0 = 32'd3;
    req1 = 1'b1; fn1 = FN_SUB; a1 = 32'd2;  b1 = 32'd9;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("tie%0d_rr_ack0", i), rr_ack0, (i % 2 == 0));
      chk($sformatf("tie%0d_rr_ack1", i), rr_ack1, (i % 2 == 1));
      chk($sformatf("tie%0d_fx_ack0", i), fx_ack0, 1);
      chk($sformatf("tie%0d_fx_ack1", i), fx_ack1, 0);
      step();
      chk($sformatf("tie%0d_rr_v0", i), rr_v0, (i % 2 == 0));
      chk($sformatf("tie%0d_rr_v1", i), rr_v1, (i % 2 == 1));
      chk($sformatf("tie%0d_rr_data", i), rr_data, (i % 2 == 0) ? 32'd7 : 32'hFFFF_FFF9);
      chk($sformatf("tie%0d_rr_flags", i), rr_flags, (i % 2 == 0) ? 4'b1000 : 4'b0010);
      chk($sformatf("tie%0d_fx_v1", i), fx_v1, 0);
      chk($sformatf("tie%0d_fx_data", i), fx_data, 7);
      step();
      chk($sformatf("tie%0d_rr_idle", i), rr_busy, 0);
    end
    // req0 drops: fixed-priority instance finally serves requester 1
    req0 = 1'b0;
    step();
    req1 = 1'b0;
    chk("fx_req1_ack1", fx_ack1, 1); chk("fx_req1_ack0", fx_ack0, 0);
    chk("rr_req1_ack1", rr_ack1, 1);
    step();
    chk("fx_req1_v1", fx_v1, 1);     chk("fx_req1_data", fx_data, 32'hFFFF_FFF9);
    step();
    chk("fx_req1_idle", fx_busy, 0);

    // ---------------- stalled response, SUB 0x80000000 - 0x80000000 ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    req1 = 1'b1; fn1 = FN_SUB; a1 = 32'h8000_0000; b1 = 32'h8000_0000;
    rsp_ready1 = 1'b0; rsp_ready0 = 1'b1;      // non-owner ready must be ignored
    step();
    chk("stall_ack1", rr_ack1, 1);
    req1 = 1'b0;
    req0 = 1'b1; fn0 = FN_ADD; a0 = 32'd5; b0 = 32'd7;
    step();                                   // EXEC edge
    for (int i = 0; i < 10; i++) begin
      a1 = 32'(i); fn1 = FN_ADD;              // changes outside IDLE have no effect
      chk($sformatf("stall%0d_v1", i), rr_v1, 1);
      chk($sformatf("stall%0d_v0", i), rr_v0, 0);
      chk($sformatf("stall%0d_ack0", i), rr_ack0, 0);
      chk($sformatf("stall%0d_data", i), rr_data, 0);
      chk($sformatf("stall%0d_flags", i), rr_flags, 4'b0101);
      chk($sformatf("stall%0d_in1", i), rr_in1, 32'h8000_0000);
      step();
    end
    rsp_ready1 = 1'b1;
    step();
    chk("stall_release_v1", rr_v1, 0);
    chk("stall_release_idle", rr_busy, 0);
    step();                                   // req0 still held -> served now
    req0 = 1'b0;
    chk("after_stall_ack0", rr_ack0, 1);
    chk("after_stall_in1", rr_in1, 5);
    step();
    chk("after_stall_v0", rr_v0, 1);
    chk("after_stall_data", rr_data, 12);
    step();
    chk("after_stall_idle", rr_busy, 0);

    // ---------------- reset during EXEC aborts the operation ----------------
    req0 = 1'b1; fn0 = FN_ADD; a0 = 32'd1; b0 = 32'd2; rsp_ready0 = 1'b1;
    step();
    req0 = 1'b0;
    chk("abort_ack0", rr_ack0, 1);
    rst = 1'b1;
    step();                                   // reset edge while in EXEC
    rst = 1'b0;
    chk("abort_ack0_clr", rr_ack0, 0);
    chk("abort_v0", rr_v0, 0);       chk("abort_busy", rr_busy, 0);
    chk("abort_data", rr_data, 0);   chk("abort_flags", rr_flags, 0);
    chk("abort_in1", rr_in1, 0);     chk("abort_in2", rr_in2, 0);
    chk("abort_fn", rr_fn, 0);
    step();
    chk("abort_no_v0", rr_v0, 0);    chk("abort_still_idle", rr_busy, 0);
    req0 = 1'b1; a0 = 32'd20; b0 = 32'd22;
    step();
    req0 = 1'b0;
    chk("post_abort_ack0", rr_ack0, 1);
    step();
    chk("post_abort_v0", rr_v0, 1);
    chk("post_abort_data", rr_data, 42);
    step();
    chk("post_abort_idle", rr_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
